// File: rtl/bp_pkg.sv
// Shared types and saturating-counter helpers for the branch predictor.
package bp_pkg;

  typedef enum logic {
    BP_IDLE  = 1'b0,
    BP_CLEAR = 1'b1
  } bp_state_t;

  // Widest direction counter the helpers below support.
  localparam int unsigned CTR_MAX_BITS = 8;

  typedef logic [CTR_MAX_BITS-1:0] ctr_t;

  // Saturating step toward taken/not-taken, clamped to [0, ctrMax].
  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken, input ctr_t ctrMax);
    ctr_t r;
    r = ctr;
    if (taken) begin
      if (ctr != ctrMax) r = ctr + ctr_t'(1);
    end else begin
      if (ctr != '0) r = ctr - ctr_t'(1);
    end
    return r;
  endfunction

  // Weakly-taken init: MSB set, all lower bits clear.
  function automatic ctr_t ctr_weak_taken(input int unsigned bits);
    return ctr_t'(1) << (bits - 1);
  endfunction

endpackage

// File: rtl/bp_clear_fsm.sv
// Table-clear sequencer: walks every entry once, one per cycle, while busy.
module bp_clear_fsm
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        Clear_i,
  output logic                        Busy_o,
  output logic [$clog2(ENTRIES)-1:0]  clearIdx_o,
  output logic                        clearWe_c
);

  localparam int unsigned IDX_BITS = $clog2(ENTRIES);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(ENTRIES - 1);

  bp_state_t           state;
  bp_state_t           stateNext;
  logic [IDX_BITS-1:0] ptr;
  logic [IDX_BITS-1:0] ptrNext;
  logic                busyQ;

  // State, pointer and registered busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BP_IDLE;
      ptr   <= '0;
      busyQ <= 1'b0;
    end else begin
      state <= stateNext;
      ptr   <= ptrNext;
      busyQ <= (stateNext == BP_CLEAR);
    end
  end

  // Next state: a clear pulse in IDLE starts a sweep that ends after the last entry.
  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    clearWe_c = 1'b0;
    case (state)
      BP_IDLE: begin
        if (Clear_i) begin
          stateNext = BP_CLEAR;
          ptrNext   = '0;
        end
      end
      BP_CLEAR: begin
        clearWe_c = 1'b1;
        ptrNext   = ptr + IDX_BITS'(1);
        if (ptr == LAST_IDX) stateNext = BP_IDLE;
      end
    endcase
  end

  assign Busy_o     = busyQ;
  assign clearIdx_o = ptr;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters for fetch-time prediction.
// Optional performance counters are enabled with BRANCH_PREDICTOR_PERF_EN.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ENTRIES    = 16,
  parameter int unsigned TAG_BITS   = 8,
  parameter int unsigned CTR_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] PCF_i,
  output logic                  PredTakenF_o,
  output logic [DATA_WIDTH-1:0] PredTargetF_o,
  input  logic                  UpdateEn_i,
  input  logic [DATA_WIDTH-1:0] UpdatePC_i,
  input  logic                  UpdateTaken_i,
  input  logic                  UpdateJump_i,
  input  logic [DATA_WIDTH-1:0] UpdateTarget_i,
  input  logic                  Clear_i,
  output logic                  Busy_o
`ifdef BRANCH_PREDICTOR_PERF_EN
  ,
  output logic [31:0]           PerfLookups_o,
  output logic [31:0]           PerfHits_o,
  output logic [31:0]           PerfMispredicts_o
`endif
);

  localparam int unsigned IDX_BITS = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(ctr_weak_taken(CTR_BITS));

  logic [ENTRIES-1:0]                 validQ;
  logic [ENTRIES-1:0][CTR_BITS-1:0]   ctrQ;
  logic [ENTRIES-1:0][TAG_BITS-1:0]   tagQ;
  logic [ENTRIES-1:0][DATA_WIDTH-1:0] targetQ;

  logic [IDX_BITS-1:0] clearIdx;
  logic                clearWe;

  logic [IDX_BITS-1:0] lkIdx;
  logic [TAG_BITS-1:0] lkTag;
  logic                lkHit;

  logic [IDX_BITS-1:0] upIdx;
  logic [TAG_BITS-1:0] upTag;
  logic                upHit;
  logic                upAct;
  logic                upAlloc;
  logic                upCtrWe;
  logic                upTgtWe;
  logic [CTR_BITS-1:0] upCtrVal;

  // Address bits outside the index/tag fields are intentionally ignored.
  logic unusedPcBits;
  assign unusedPcBits = ^{PCF_i, UpdatePC_i};

  bp_clear_fsm #(
    .ENTRIES (ENTRIES)
  ) uClearFsm (
    .clk        (clk),
    .rst        (rst),
    .Clear_i    (Clear_i),
    .Busy_o     (Busy_o),
    .clearIdx_o (clearIdx),
    .clearWe_c  (clearWe)
  );

  // Fetch lookup reads pre-update contents; masked while the table is being cleared.
  assign lkIdx         = PCF_i[IDX_BITS+1:2];
  assign lkTag         = PCF_i[IDX_BITS+2 +: TAG_BITS];
  assign lkHit         = validQ[lkIdx] && (tagQ[lkIdx] == lkTag);
  assign PredTakenF_o  = lkHit && ctrQ[lkIdx][CTR_BITS-1] && !Busy_o;
  assign PredTargetF_o = PredTakenF_o ? targetQ[lkIdx] : '0;

  assign upIdx = UpdatePC_i[IDX_BITS+1:2];
  assign upTag = UpdatePC_i[IDX_BITS+2 +: TAG_BITS];
  assign upHit = validQ[upIdx] && (tagQ[upIdx] == upTag);
  assign upAct = UpdateEn_i && !Busy_o;

  // Resolve the write for this cycle's Execute outcome; not-taken misses never allocate.
  always_comb begin
    upAlloc  = 1'b0;
    upCtrWe  = 1'b0;
    upTgtWe  = 1'b0;
    upCtrVal = ctrQ[upIdx];
    if (upAct) begin
      if (upHit) begin
        upCtrWe = 1'b1;
        upTgtWe = UpdateJump_i || UpdateTaken_i;
        if (UpdateJump_i) upCtrVal = CTR_MAX;
        else upCtrVal = CTR_BITS'(ctr_next(ctr_t'(ctrQ[upIdx]), UpdateTaken_i, ctr_t'(CTR_MAX)));
      end else if (UpdateTaken_i || UpdateJump_i) begin
        upAlloc  = 1'b1;
        upCtrWe  = 1'b1;
        upTgtWe  = 1'b1;
        upCtrVal = UpdateJump_i ? CTR_MAX : CTR_WEAK;
      end
    end
  end

  // Valid bits and counters: async reset, swept by the clear sequencer, else updated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validQ <= '0;
      ctrQ   <= '0;
    end else if (clearWe) begin
      validQ[clearIdx] <= 1'b0;
      ctrQ[clearIdx]   <= '0;
    end else begin
      if (upAlloc) validQ[upIdx] <= 1'b1;
      if (upCtrWe) ctrQ[upIdx]   <= upCtrVal;
    end
  end

  // Tag and target storage carries no reset; qualified by the valid bit.
  always_ff @(posedge clk) begin
    if (upTgtWe) targetQ[upIdx] <= UpdateTarget_i;
    if (upAlloc) tagQ[upIdx]    <= upTag;
  end

`ifdef BRANCH_PREDICTOR_PERF_EN
  logic [31:0] perfLookupsQ;
  logic [31:0] perfHitsQ;
  logic [31:0] perfMispredQ;

  // Event counters; a miss counts as a not-taken prediction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perfLookupsQ <= '0;
      perfHitsQ    <= '0;
      perfMispredQ <= '0;
    end else begin
      if (!Busy_o) perfLookupsQ <= perfLookupsQ + 32'd1;
      if (!Busy_o && lkHit) perfHitsQ <= perfHitsQ + 32'd1;
      if (upAct && ((upHit && ctrQ[upIdx][CTR_BITS-1]) != UpdateTaken_i))
        perfMispredQ <= perfMispredQ + 32'd1;
    end
  end

  assign PerfLookups_o     = perfLookupsQ;
  assign PerfHits_o        = perfHitsQ;
  assign PerfMispredicts_o = perfMispredQ;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (ENTRIES=16, TAG_BITS=8, CTR_BITS=2).
module tb_branch_predictor;

  logic        clk;
  logic        rstN;
  logic [31:0] pcf;
  logic        predTaken;
  logic [31:0] predTarget;
  logic        updEn;
  logic [31:0] updPc;
  logic        updTaken;
  logic        updJump;
  logic [31:0] updTarget;
  logic        clearIn;
  logic        busy;
`ifdef BRANCH_PREDICTOR_PERF_EN
  logic [31:0] perfLookups;
  logic [31:0] perfHits;
  logic [31:0] perfMis;
`endif

  int checks = 0;
  int errors = 0;

  branch_predictor #(
    .DATA_WIDTH (32),
    .ENTRIES    (16),
    .TAG_BITS   (8),
    .CTR_BITS   (2)
  ) dut (
    .clk            (clk),
    .rst            (rstN),
    .PCF_i          (pcf),
    .PredTakenF_o   (predTaken),
    .PredTargetF_o  (predTarget),
    .UpdateEn_i     (updEn),
    .UpdatePC_i     (updPc),
    .UpdateTaken_i  (updTaken),
    .UpdateJump_i   (updJump),
    .UpdateTarget_i (updTarget),
    .Clear_i        (clearIn),
    .Busy_o         (busy)
`ifdef BRANCH_PREDICTOR_PERF_EN
    ,
    .PerfLookups_o     (perfLookups),
    .PerfHits_o        (perfHits),
    .PerfMispredicts_o (perfMis)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: per-index entry contents plus remaining clear cycles.
  bit          mValid [16];
  int          mTag   [16];
  logic [31:0] mTgt   [16];
  int          mCtr   [16];
  int          mBusy;
  int unsigned mLook, mHit, mMis;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      mValid[i] = 1'b0;
      mCtr[i]   = 0;
      mTag[i]   = 0;
      mTgt[i]   = '0;
    end
    mBusy = 0;
    mLook = 0;
    mHit  = 0;
    mMis  = 0;
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) & 32'hF);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc >> 6) & 32'hFF);
  endfunction

  function automatic void model_lookup(input logic [31:0] pc, output bit hit,
                                       output bit taken, output logic [31:0] tgt);
    int i;
    i     = idx_of(pc);
    hit   = mValid[i] && (mTag[i] == tag_of(pc));
    taken = hit && (mCtr[i] >= 2) && (mBusy == 0);
    tgt   = taken ? mTgt[i] : 32'h0;
  endfunction

  // Apply one rising edge to the model using the inputs held during the cycle.
  function automatic void model_edge();
    bit          h, tk, uHit;
    logic [31:0] tg;
    int          i;
    if (!rstN) return;
    model_lookup(pcf, h, tk, tg);
    if (mBusy == 0) begin
      mLook++;
      if (h) mHit++;
    end
    if (mBusy > 0) begin
      mBusy--;
      return;
    end
    if (updEn) begin
      i    = idx_of(updPc);
      uHit = mValid[i] && (mTag[i] == tag_of(updPc));
      if ((uHit && mCtr[i] >= 2) != updTaken) mMis++;
      if (uHit) begin
        if (updJump) begin
          mCtr[i] = 3;
          mTgt[i] = updTarget;
        end else if (updTaken) begin
          mCtr[i] = (mCtr[i] < 3) ? mCtr[i] + 1 : 3;
          mTgt[i] = updTarget;
        end else begin
          mCtr[i] = (mCtr[i] > 0) ? mCtr[i] - 1 : 0;
        end
      end else if (updTaken || updJump) begin
        mValid[i] = 1'b1;
        mTag[i]   = tag_of(updPc);
        mTgt[i]   = updTarget;
        mCtr[i]   = updJump ? 3 : 2;
      end
    end
    if (clearIn) begin
      mBusy = 16;
      for (int k = 0; k < 16; k++) begin
        mValid[k] = 1'b0;
        mCtr[k]   = 0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    updEn    = 1'b0;
    updTaken = 1'b0;
    updJump  = 1'b0;
    clearIn  = 1'b0;
  endtask

  task automatic do_update(input logic [31:0] pc, input bit taken, input bit jump,
                           input logic [31:0] tgt);
    updEn     = 1'b1;
    updPc     = pc;
    updTaken  = taken;
    updJump   = jump;
    updTarget = tgt;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    idle_inputs();
    pcf = 32'h100;
    updPc = '0;
    updTarget = '0;
    model_reset();
    #2;
    checks++;
    if (predTaken !== 1'b0) begin
      errors++;
      $display("FAIL reset_pred: got %0b expected 0", predTaken);
    end
    checks++;
    if (predTarget !== 32'h0) begin
      errors++;
      $display("FAIL reset_target: got %h expected 00000000", predTarget);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %0b expected 0", busy);
    end
    tick();
    tick();
    rstN = 1'b1;
    tick();
  endtask

  task automatic test_counter();
    pcf = 32'h100;
    updEn = 1'b1; updPc = 32'h100; updTaken = 1'b1; updJump = 1'b0; updTarget = 32'h80;
    #1;
    checks++;
    if (predTaken !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_lookup: got %0b expected 0", predTaken);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if ({predTaken, predTarget} !== {1'b1, 32'h80}) begin
      errors++;
      $display("FAIL alloc_weak: got %0b/%h expected 1/00000080", predTaken, predTarget);
    end
    for (int k = 0; k < 3; k++) begin
      do_update(32'h100, 1'b0, 1'b0, 32'h0);
      checks++;
      if ({predTaken, predTarget} !== {1'b0, 32'h0}) begin
        errors++;
        $display("FAIL not_taken_%0d: got %0b/%h expected 0/00000000", k, predTaken, predTarget);
      end
    end
    do_update(32'h100, 1'b1, 1'b0, 32'h84);
    checks++;
    if (predTaken !== 1'b0) begin
      errors++;
      $display("FAIL sat_low: got %0b expected 0", predTaken);
    end
    for (int k = 0; k < 4; k++) do_update(32'h100, 1'b1, 1'b0, 32'h88);
    do_update(32'h100, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({predTaken, predTarget} !== {1'b1, 32'h88}) begin
      errors++;
      $display("FAIL sat_high: got %0b/%h expected 1/00000088", predTaken, predTarget);
    end
  endtask

  task automatic test_jump_alias();
    do_update(32'h40, 1'b1, 1'b1, 32'h200);
    pcf = 32'h40;
    #1;
    checks++;
    if ({predTaken, predTarget} !== {1'b1, 32'h200}) begin
      errors++;
      $display("FAIL jump_alloc: got %0b/%h expected 1/00000200", predTaken, predTarget);
    end
    do_update(32'h40, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({predTaken, predTarget} !== {1'b1, 32'h200}) begin
      errors++;
      $display("FAIL jump_ctr_max: got %0b/%h expected 1/00000200", predTaken, predTarget);
    end
    do_update(32'h440, 1'b1, 1'b0, 32'h300);
    pcf = 32'h40;
    #1;
    checks++;
    if ({predTaken, predTarget} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL alias_old_tag: got %0b/%h expected 0/00000000", predTaken, predTarget);
    end
    pcf = 32'h440;
    #1;
    checks++;
    if ({predTaken, predTarget} !== {1'b1, 32'h300}) begin
      errors++;
      $display("FAIL alias_new_tag: got %0b/%h expected 1/00000300", predTaken, predTarget);
    end
  endtask

  task automatic test_no_alloc();
    do_update(32'h20, 1'b0, 1'b0, 32'h500);
    pcf = 32'h20;
    #1;
    checks++;
    if ({predTaken, predTarget} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL no_alloc: got %0b/%h expected 0/00000000", predTaken, predTarget);
    end
    pcf = 32'h443;
    #1;
    checks++;
    if ({predTaken, predTarget} !== {1'b1, 32'h300}) begin
      errors++;
      $display("FAIL low_bits_ignored: got %0b/%h expected 1/00000300", predTaken, predTarget);
    end
  endtask

  task automatic test_clear();
    logic [31:0] pc;
    for (int i = 0; i < 16; i++) do_update(32'h800 | (i << 2), 1'b1, 1'b0, 32'h1000 + i * 32'h100);
    pcf = 32'h804;
    #1;
    checks++;
    if ({predTaken, predTarget} !== {1'b1, 32'h1100}) begin
      errors++;
      $display("FAIL fill_hit: got %0b/%h expected 1/00001100", predTaken, predTarget);
    end
    updEn = 1'b1; updPc = 32'hC00; updTaken = 1'b1; updJump = 1'b0; updTarget = 32'hABC;
    clearIn = 1'b1;
    tick();
    clearIn = 1'b0;
    for (int c = 0; c < 16; c++) begin
      updEn = 1'b1; updPc = 32'h900 | (c << 2); updTaken = 1'b1; updTarget = 32'h7000;
      pcf = 32'h800 | (c << 2);
      clearIn = (c == 3);
      #1;
      checks++;
      if ({busy, predTaken, predTarget} !== {1'b1, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL clear_cycle_%0d: busy/pred/target got %0b/%0b/%h expected 1/0/00000000",
                 c, busy, predTaken, predTarget);
      end
      tick();
    end
    idle_inputs();
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_length: busy got %0b expected 0 after 16 cycles", busy);
    end
    for (int i = 0; i < 18; i++) begin
      pc = (i < 16) ? (32'h800 | (i << 2)) : ((i == 16) ? 32'hC00 : 32'h904);
      pcf = pc;
      #1;
      checks++;
      if (predTaken !== 1'b0) begin
        errors++;
        $display("FAIL after_clear_%h: got %0b expected 0", pc, predTaken);
      end
    end
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] tag;
    tag = 32'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) tag = tag | 32'h80;
    return (tag << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3))
           | ($urandom & 32'hFFFF_C000);
  endfunction

  task automatic test_random();
    bit          h, tk;
    logic [31:0] tg;
    for (int n = 0; n < 600; n++) begin
      pcf       = rand_pc();
      updEn     = ($urandom_range(0, 9) < 6);
      updPc     = rand_pc();
      updJump   = ($urandom_range(0, 4) == 0);
      updTaken  = updJump ? 1'b1 : 1'($urandom_range(0, 1));
      updTarget = $urandom & 32'hFFFF_FFFC;
      clearIn   = ($urandom_range(0, 99) < 2);
      #1;
      model_lookup(pcf, h, tk, tg);
      checks++;
      if ({busy, predTaken, predTarget} !== {(mBusy > 0), tk, tg}) begin
        errors++;
        $display("FAIL random_%0d pc=%h: busy/pred/target got %0b/%0b/%h expected %0b/%0b/%h",
                 n, pcf, busy, predTaken, predTarget, (mBusy > 0), tk, tg);
      end
      tick();
    end
    idle_inputs();
    while (mBusy > 0) tick();
  endtask

  task automatic test_reset_mid_clear();
    do_update(32'h3C, 1'b1, 1'b0, 32'h44);
    clearIn = 1'b1;
    tick();
    clearIn = 1'b0;
    repeat (4) tick();
    rstN = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_clear_busy: got %0b expected 0", busy);
    end
    model_reset();
    tick();
    rstN = 1'b1;
    pcf = 32'h3C;
    tick();
    checks++;
    if ({busy, predTaken} !== {1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_clear_entry: busy/pred got %0b/%0b expected 0/0", busy, predTaken);
    end
  endtask

`ifdef BRANCH_PREDICTOR_PERF_EN
  task automatic test_perf();
    do_update(32'h3C, 1'b1, 1'b0, 32'h44);
    clearIn = 1'b1;
    tick();
    clearIn = 1'b0;
    repeat (20) tick();
    checks++;
    if (perfLookups !== 32'(mLook)) begin
      errors++;
      $display("FAIL perf_lookups: got %0d expected %0d", perfLookups, mLook);
    end
    checks++;
    if (perfHits !== 32'(mHit)) begin
      errors++;
      $display("FAIL perf_hits: got %0d expected %0d", perfHits, mHit);
    end
    checks++;
    if (perfMis !== 32'(mMis)) begin
      errors++;
      $display("FAIL perf_mispredicts: got %0d expected %0d", perfMis, mMis);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_counter();
    test_jump_alias();
    test_no_alloc();
    test_clear();
    test_random();
    test_reset_mid_clear();
`ifdef BRANCH_PREDICTOR_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
